// File: rtl/cpu_pkg.sv
// Shared constants and memory-operation encoding for the 16-bit cpu pipeline.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;
    localparam int REG_W  = 3;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_LD   = 2'd1,
        MEM_ST   = 2'd2
    } memOp_t;

    // A store wins when both read and write are flagged.
    function automatic memOp_t decodeMemOp(input logic memRead, input logic memWrite);
        if (memWrite)
            return MEM_ST;
        else if (memRead)
            return MEM_LD;
        else
            return MEM_NONE;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: stall decode when it reads the register an EX load is about to fill.
module load_use_detect #(
    parameter int REG_W = 3
) (
    input  logic             exValid,
    input  logic             flush,
    input  logic             exMemRead,
    input  logic             exRegWrite,
    input  logic [REG_W-1:0] exDestReg,
    input  logic [REG_W-1:0] decSrcA,
    input  logic [REG_W-1:0] decSrcB,
    input  logic             decUseA,
    input  logic             decUseB,
    output logic             ldUseStall
);

    logic liveLoad;
    logic hitA;
    logic hitB;

    always_comb begin
        liveLoad   = exValid & ~flush & exMemRead & exRegWrite;
        hitA       = decUseA & (decSrcA == exDestReg);
        hitB       = decUseB & (decSrcB == exDestReg);
        ldUseStall = liveLoad & (hitA | hitB);
    end

endmodule

// File: rtl/mem_stage.sv
// EX->MEM->WB stage: registers execute results, drives data memory, captures writeback and counts retired loads/stores.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int REG_W  = cpu_pkg::REG_W,
    parameter int CNT_W  = cpu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exValid,
    input  logic [DATA_W-1:0] exAluResult,
    input  logic [DATA_W-1:0] exStoreData,
    input  logic              exMemRead,
    input  logic              exMemWrite,
    input  logic              exRegWrite,
    input  logic [REG_W-1:0]  exDestReg,
    input  logic              flush,
    input  logic              hold,
    input  logic [REG_W-1:0]  decSrcA,
    input  logic [REG_W-1:0]  decSrcB,
    input  logic              decUseA,
    input  logic              decUseB,
    output logic [ADDR_W-1:0] memAdrx,
    output logic              memWrite,
    output logic [DATA_W-1:0] memDataOut,
    input  logic [DATA_W-1:0] memDataIn,
    output logic              ldUseStall,
    output logic              wbValid,
    output logic              wbRegWrite,
    output logic [REG_W-1:0]  wbDestReg,
    output logic [DATA_W-1:0] wbData,
    output logic [CNT_W-1:0]  loadCount,
    output logic [CNT_W-1:0]  storeCount
);

    logic              memValid;
    logic [DATA_W-1:0] memAlu;
    logic [DATA_W-1:0] memStore;
    memOp_t            memOp;
    logic              memRegWr;
    logic [REG_W-1:0]  memDest;
    logic              storeIssued;

    logic [CNT_W-1:0]  loadCnt;
    logic [CNT_W-1:0]  storeCnt;

    logic              advance;

    assign advance = ~hold;

    always_comb begin
        memAdrx    = memAlu[ADDR_W-1:0];
        memDataOut = memStore;
        memWrite   = memValid & (memOp == MEM_ST) & ~storeIssued;
        loadCount  = loadCnt;
        storeCount = storeCnt;
    end

    // MEM register; a store never requests a register write.
    always_ff @(posedge clk) begin
        if (reset) begin
            memValid <= 1'b0;
            memAlu   <= '0;
            memStore <= '0;
            memOp    <= MEM_NONE;
            memRegWr <= 1'b0;
            memDest  <= '0;
        end else if (advance) begin
            memValid <= exValid & ~flush;
            memAlu   <= exAluResult;
            memStore <= exStoreData;
            memOp    <= decodeMemOp(exMemRead, exMemWrite);
            memRegWr <= exRegWrite & ~exMemWrite;
            memDest  <= exDestReg;
        end
    end

    // Remembers that a held store already hit dmem so it writes exactly once.
    always_ff @(posedge clk) begin
        if (reset)
            storeIssued <= 1'b0;
        else if (advance)
            storeIssued <= 1'b0;
        else if (memWrite)
            storeIssued <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbValid    <= 1'b0;
            wbRegWrite <= 1'b0;
            wbDestReg  <= '0;
            wbData     <= '0;
        end else if (advance) begin
            wbValid    <= memValid;
            wbRegWrite <= memValid & memRegWr;
            wbDestReg  <= memDest;
            wbData     <= (memOp == MEM_LD) ? memDataIn : memAlu;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            loadCnt  <= '0;
            storeCnt <= '0;
        end else if (advance && memValid) begin
            if (memOp == MEM_LD && loadCnt != '1)
                loadCnt <= loadCnt + 1'b1;
            if (memOp == MEM_ST && storeCnt != '1)
                storeCnt <= storeCnt + 1'b1;
        end
    end

    load_use_detect #(
        .REG_W(REG_W)
    ) u_loadUse (
        .exValid   (exValid),
        .flush     (flush),
        .exMemRead (exMemRead),
        .exRegWrite(exRegWrite),
        .exDestReg (exDestReg),
        .decSrcA   (decSrcA),
        .decSrcB   (decSrcB),
        .decUseA   (decUseA),
        .decUseB   (decUseB),
        .ldUseStall(ldUseStall)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        exValid, exMemRead, exMemWrite, exRegWrite, flush, hold;
    logic [15:0] exAluResult, exStoreData;
    logic [2:0]  exDestReg, decSrcA, decSrcB;
    logic        decUseA, decUseB;
    logic [10:0] memAdrx;
    logic        memWrite, ldUseStall, wbValid, wbRegWrite;
    logic [15:0] memDataOut, memDataIn, wbData, loadCount, storeCount;
    logic [2:0]  wbDestReg;

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_W(16),
        .ADDR_W(11),
        .REG_W (3),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .exValid    (exValid),
        .exAluResult(exAluResult),
        .exStoreData(exStoreData),
        .exMemRead  (exMemRead),
        .exMemWrite (exMemWrite),
        .exRegWrite (exRegWrite),
        .exDestReg  (exDestReg),
        .flush      (flush),
        .hold       (hold),
        .decSrcA    (decSrcA),
        .decSrcB    (decSrcB),
        .decUseA    (decUseA),
        .decUseB    (decUseB),
        .memAdrx    (memAdrx),
        .memWrite   (memWrite),
        .memDataOut (memDataOut),
        .memDataIn  (memDataIn),
        .ldUseStall (ldUseStall),
        .wbValid    (wbValid),
        .wbRegWrite (wbRegWrite),
        .wbDestReg  (wbDestReg),
        .wbData     (wbData),
        .loadCount  (loadCount),
        .storeCount (storeCount)
    );

    // Environment data memory, written by the DUT's own strobe.
    logic [15:0] dmem [0:2047];
    always @(posedge clk) if (memWrite) dmem[memAdrx] <= memDataOut;
    assign memDataIn = dmem[memAdrx];

    // Reference model: one instruction slot in MEM, one result in WB, memory image, counts.
    typedef struct packed {
        bit        v;
        bit [15:0] addr;
        bit [15:0] sdata;
        bit        isLoad;
        bit        isStore;
        bit        writesReg;
        bit [2:0]  dst;
    } instr_t;

    instr_t      mInstr;
    bit          mWritten;
    bit          mWbV, mWbRw;
    bit [2:0]    mWbDst;
    bit [15:0]   mWbData;
    int unsigned mLoads, mStores;
    bit [15:0]   refMem [0:2047];
    int unsigned writeCycles;

    int errCnt = 0;
    int chkCnt = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drv(input bit v, input bit [15:0] a, input bit [15:0] sd, input bit rd,
                       input bit wr, input bit rw, input bit [2:0] d, input bit fl, input bit hd);
        exValid = v; exAluResult = a; exStoreData = sd; exMemRead = rd;
        exMemWrite = wr; exRegWrite = rw; exDestReg = d; flush = fl; hold = hd;
    endtask

    task automatic idle();
        drv(0, 16'h0, 16'h0, 0, 0, 0, 3'd0, 0, 0);
    endtask

    // Check every output against the model, then advance one edge.
    task automatic step();
        bit        expWr;
        bit        expStall;
        bit [15:0] loadVal;
        #2;
        expWr = mInstr.v && mInstr.isStore && !mWritten;
        expStall = exValid && !flush && exMemRead && exRegWrite &&
                   ((decUseA && decSrcA == exDestReg) || (decUseB && decSrcB == exDestReg));
        checkVal("memWrite",   32'(memWrite),   32'(expWr));
        checkVal("memAdrx",    32'(memAdrx),    32'(mInstr.addr % 2048));
        checkVal("memDataOut", 32'(memDataOut), 32'(mInstr.sdata));
        checkVal("ldUseStall", 32'(ldUseStall), 32'(expStall));
        checkVal("wbValid",    32'(wbValid),    32'(mWbV));
        checkVal("wbRegWrite", 32'(wbRegWrite), 32'(mWbRw));
        checkVal("wbDestReg",  32'(wbDestReg),  32'(mWbDst));
        checkVal("wbData",     32'(wbData),     32'(mWbData));
        checkVal("loadCount",  32'(loadCount),  mLoads);
        checkVal("storeCount", 32'(storeCount), mStores);
        if (memWrite) writeCycles++;
        @(posedge clk);
        loadVal = refMem[mInstr.addr % 2048];
        if (expWr) refMem[mInstr.addr % 2048] = mInstr.sdata;
        if (reset) begin
            mInstr = '0; mWritten = 0; mWbV = 0; mWbRw = 0; mWbDst = 0; mWbData = 0;
            mLoads = 0; mStores = 0;
        end else if (hold) begin
            if (expWr) mWritten = 1;
        end else begin
            mWbV    = mInstr.v;
            mWbRw   = mInstr.v && mInstr.writesReg;
            mWbDst  = mInstr.dst;
            mWbData = mInstr.isLoad ? loadVal : mInstr.addr;
            if (mInstr.v && mInstr.isLoad  && mLoads  < 65535) mLoads++;
            if (mInstr.v && mInstr.isStore && mStores < 65535) mStores++;
            mInstr.v         = exValid && !flush;
            mInstr.addr      = exAluResult;
            mInstr.sdata     = exStoreData;
            mInstr.isStore   = exMemWrite;
            mInstr.isLoad    = exMemRead && !exMemWrite;
            mInstr.writesReg = exRegWrite && !exMemWrite;
            mInstr.dst       = exDestReg;
            mWritten = 0;
        end
        #1;
    endtask

    int unsigned w0, s0;
    logic [10:0] heldAdrx;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            dmem[i]   = 16'(i * 3 + 7);
            refMem[i] = 16'(i * 3 + 7);
        end
        mInstr = '0; mWritten = 0; mWbV = 0; mWbRw = 0; mWbDst = 0; mWbData = 0;
        mLoads = 0; mStores = 0; writeCycles = 0;
        decSrcA = 0; decSrcB = 0; decUseA = 0; decUseB = 0;
        idle();
        reset = 1;
        @(posedge clk); #1;
        step();
        reset = 0;
        checkVal("rst_wbData",    32'(wbData), 32'h0);
        checkVal("rst_loadCount", 32'(loadCount), 32'h0);

        // Store then back-to-back load of the same address.
        w0 = writeCycles;
        drv(1, 16'h0005, 16'h1234, 0, 1, 0, 3'd0, 0, 0); step();
        drv(1, 16'h0005, 16'h0000, 1, 0, 1, 3'd1, 0, 0); step();
        idle(); step();
        checkVal("t1_wbData", 32'(wbData), 32'h1234);
        step();
        checkVal("t1_writes", writeCycles - w0, 1);

        // Load-use stall with and without the operand actually used.
        drv(1, 16'h0010, 16'h0, 1, 0, 1, 3'd2, 0, 0);
        decSrcA = 3'd2; decUseA = 1;
        #1 checkVal("t2_stall", 32'(ldUseStall), 32'h1);
        decUseA = 0;
        #1 checkVal("t2_nostall", 32'(ldUseStall), 32'h0);
        step();
        decSrcA = 0; idle(); step();

        // Store held for three cycles writes exactly once.
        w0 = writeCycles; s0 = storeCount;
        drv(1, 16'h0003, 16'h00FF, 0, 1, 0, 3'd0, 0, 0); step();
        idle(); hold = 1; step(); step(); step();
        hold = 0; step(); step();
        checkVal("t3_writes", writeCycles - w0, 1);
        checkVal("t3_mem3", 32'(dmem[3]), 32'h00FF);
        checkVal("t3_storeCount", 32'(storeCount), s0 + 1);

        // Flushed store never writes; flush+hold keeps MEM.
        w0 = writeCycles; s0 = storeCount;
        drv(1, 16'h0007, 16'hAAAA, 0, 1, 0, 3'd0, 1, 0); step();
        idle(); step(); step();
        checkVal("t4_writes", writeCycles - w0, 0);
        checkVal("t4_storeCount", 32'(storeCount), s0);
        drv(1, 16'h0123, 16'h0, 0, 0, 1, 3'd4, 0, 0); step();
        heldAdrx = memAdrx;
        drv(1, 16'h0456, 16'h5555, 0, 1, 0, 3'd0, 1, 1); step();
        checkVal("t4_heldAdrx", 32'(memAdrx), 32'(heldAdrx));
        idle(); step(); step();

        // Upper address bits ignored; plain ALU result to WB.
        drv(1, 16'hF805, 16'h0, 1, 0, 1, 3'd3, 0, 0); step();
        checkVal("t5_adrx", 32'(memAdrx), 32'h005);
        drv(1, 16'hBEEF, 16'h0, 0, 0, 1, 3'd6, 0, 0); step();
        idle(); step();
        checkVal("t5_wbData", 32'(wbData), 32'hBEEF);
        step();

        // Counter saturation from a preloaded value.
        force dut.loadCnt = 16'hFFFE;
        #1 release dut.loadCnt;
        mLoads = 65534;
        repeat (3) begin drv(1, 16'h0020, 16'h0, 1, 0, 1, 3'd5, 0, 0); step(); end
        idle(); step(); step();
        checkVal("t6_loadSat", 32'(loadCount), 32'hFFFF);

        // Reset while a store sits in MEM.
        drv(1, 16'h0009, 16'h7777, 0, 1, 0, 3'd0, 0, 0); step();
        idle(); reset = 1; step();
        reset = 0; #1;
        checkVal("t6_rstWrite", 32'(memWrite), 32'h0);
        checkVal("t6_rstWbData", 32'(wbData), 32'h0);
        checkVal("t6_rstStores", 32'(storeCount), 32'h0);
        step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drv($urandom_range(0, 3) != 0, 16'(($urandom & 16'hF800) | $urandom_range(0, 15)),
                16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, 3'($urandom), $urandom_range(0, 6) == 0,
                $urandom_range(0, 4) == 0);
            decSrcA = 3'($urandom); decSrcB = 3'($urandom);
            decUseA = $urandom_range(0, 1) == 1; decUseB = $urandom_range(0, 1) == 1;
            reset = $urandom_range(0, 60) == 0;
            step();
        end
        reset = 0; idle(); step();

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
